// File: rtl/text_renderer.sv
// Character-cell text overlay: a 2x16 character buffer rendered through an
// external glyph ROM with a two-stage pixel pipeline, plus a write/clear FSM.
module text_renderer #(
  parameter int X0 = 32,
  parameter int Y0 = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       display_on,
  input  logic       ch_valid,
  input  logic [6:0] ch_data,
  output logic       ch_ready,
  input  logic       clear_req,
  output logic       busy,
  output logic [4:0] cursor,
  output logic [6:0] rom_digit,
  output logic [2:0] rom_yofs,
  input  logic [4:0] rom_bits,
  output logic       pixel
);

  localparam logic [6:0] SPACE = 7'h20;
  localparam logic [6:0] LF    = 7'h0A;
  localparam logic [9:0] X0_W  = 10'(X0);
  localparam logic [9:0] X1_W  = 10'(X0 + 128);
  localparam logic [9:0] Y0_W  = 10'(Y0);
  localparam logic [9:0] Y1_W  = 10'(Y0 + 16);
  localparam logic [8:0] X0_9  = 9'(X0);
  localparam logic [8:0] Y0_9  = 9'(Y0);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t     state_q, state_d;
  logic [4:0] cursor_q, cursor_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic [6:0] buf_q [32];
  logic [6:0] buf_d [32];

  logic       vld_p1_q, vld_p1_d;
  logic [6:0] char_p1_q, char_p1_d;
  logic [2:0] gy_p1_q, gy_p1_d;
  logic [2:0] px_p1_q, px_p1_d;
  logic       pixel_p2_q, pixel_p2_d;

  logic [6:0] relx;
  logic [3:0] rely;
  logic       in_win;

  // Bit 4 of the ROM row is the leftmost pixel of the glyph.
  function automatic logic glyph_bit(input logic [4:0] bits, input logic [2:0] px);
    case (px)
      3'd0:    glyph_bit = bits[4];
      3'd1:    glyph_bit = bits[3];
      3'd2:    glyph_bit = bits[2];
      3'd3:    glyph_bit = bits[1];
      3'd4:    glyph_bit = bits[0];
      default: glyph_bit = 1'b0;
    endcase
  endfunction

  always_comb begin
    relx   = 7'(hpos - X0_9);
    rely   = 4'(vpos - Y0_9);
    in_win = ({1'b0, hpos} >= X0_W) && ({1'b0, hpos} < X1_W) &&
             ({1'b0, vpos} >= Y0_W) && ({1'b0, vpos} < Y1_W);

    // stage 1: buffer lookup and window qualification
    vld_p1_d  = in_win & display_on;
    char_p1_d = buf_q[{rely[3], relx[6:3]}];
    gy_p1_d   = rely[2:0];
    px_p1_d   = relx[2:0];

    // stage 2: glyph bit select, blanking the gutter outside the 5x5 glyph
    pixel_p2_d = vld_p1_q & (gy_p1_q < 3'd5) & (px_p1_q < 3'd5) &
                 glyph_bit(rom_bits, px_p1_q);
  end

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    clr_idx_d = clr_idx_q;
    buf_d     = buf_q;
    ch_ready  = (state_q == IDLE) & ~clear_req;
    busy      = (state_q == CLEAR);
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_idx_d = 5'd0;
        end else if (ch_valid) begin
          if (ch_data == LF) begin
            cursor_d = {~cursor_q[4], 4'b0000};
          end else begin
            buf_d[cursor_q] = ch_data;
            cursor_d        = cursor_q + 5'd1;
          end
        end
      end
      CLEAR: begin
        buf_d[clr_idx_q] = SPACE;
        clr_idx_d        = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) begin
          state_d  = IDLE;
          cursor_d = 5'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cursor_q   <= 5'd0;
      clr_idx_q  <= 5'd0;
      for (int i = 0; i < 32; i++) buf_q[i] <= SPACE;
      vld_p1_q   <= 1'b0;
      char_p1_q  <= SPACE;
      gy_p1_q    <= 3'd0;
      px_p1_q    <= 3'd0;
      pixel_p2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      clr_idx_q  <= clr_idx_d;
      buf_q      <= buf_d;
      vld_p1_q   <= vld_p1_d;
      char_p1_q  <= char_p1_d;
      gy_p1_q    <= gy_p1_d;
      px_p1_q    <= px_p1_d;
      pixel_p2_q <= pixel_p2_d;
    end
  end

  assign cursor    = cursor_q;
  assign rom_digit = char_p1_q;
  assign rom_yofs  = gy_p1_q;
  assign pixel     = pixel_p2_q;

endmodule

// File: tb/tb_text_renderer.sv
// Bench for text_renderer: cell-level buffer/cursor model, a small glyph ROM,
// and a scoreboard that matches each pixel against the raster position 2 clocks earlier.
module tb_text_renderer;
  localparam int X0 = 32;
  localparam int Y0 = 64;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [8:0] hpos, vpos;
  logic       display_on, ch_valid, clear_req;
  logic [6:0] ch_data;
  logic       ch_ready, busy, pixel;
  logic [4:0] cursor, rom_bits;
  logic [6:0] rom_digit;
  logic [2:0] rom_yofs;

  always #5 clk = ~clk;

  text_renderer #(.X0(X0), .Y0(Y0)) dut (
    .clk(clk), .reset_n(reset_n), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .clear_req(clear_req), .busy(busy), .cursor(cursor),
    .rom_digit(rom_digit), .rom_yofs(rom_yofs), .rom_bits(rom_bits), .pixel(pixel)
  );

  // Glyph rows 5..7 are deliberately lit so the gutter blanking is exercised.
  function automatic logic [4:0] glyph(input logic [6:0] c, input logic [2:0] y);
    int t;
    if (y >= 3'd5) return 5'b11111;
    if (c == 7'h20) return 5'b00000;
    if (c == 7'h48) return (y == 3'd2) ? 5'b11111 : 5'b10001;
    t = c * 3 + y * 7 + 5;
    return 5'(t) | 5'b10000;
  endfunction

  assign rom_bits = glyph(rom_digit, rom_yofs);

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic pix; int h; int v; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  logic [6:0] mbuf [32];
  int  mcur;
  bit  mclr;
  int  midx;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbuf[i] = 7'h20;
    mcur = 0; mclr = 0; midx = 0;
  endtask

  function automatic logic exp_pix(input int h, input int v, input bit d);
    int rx, ry, px, gy;
    logic [4:0] g;
    rx = h - X0; ry = v - Y0;
    if (!d || rx < 0 || rx >= 128 || ry < 0 || ry >= 16) return 1'b0;
    px = rx % 8; gy = ry % 8;
    if (px >= 5 || gy >= 5) return 1'b0;
    g = glyph(mbuf[(ry / 8) * 16 + rx / 8], 3'(gy));
    return g[4 - px];
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check control outputs, queue the pixel, advance the model.
  task automatic cyc_drive(input int h, input int v, input bit d, input bit cv,
                           input logic [6:0] cd, input bit cr);
    hpos = 9'(h); vpos = 9'(v); display_on = d;
    ch_valid = cv; ch_data = cd; clear_req = cr;
    #1;
    chk("ch_ready", ch_ready, (!mclr && !cr) ? 1 : 0);
    chk("busy", busy, mclr ? 1 : 0);
    chk("cursor", cursor, mcur);
    sbq.push_back('{cyc + 2, exp_pix(h, v, d), h, v});
    if (!mclr) begin
      if (cr) begin
        mclr = 1; midx = 0;
      end else if (cv) begin
        if (cd == 7'h0A) mcur = (mcur < 16) ? 16 : 0;
        else begin
          mbuf[mcur] = cd;
          mcur = (mcur + 1) % 32;
        end
      end
    end else begin
      mbuf[midx] = 7'h20;
      if (midx == 31) begin mclr = 0; mcur = 0; end
      midx++;
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [6:0] c);
    cyc_drive(0, 0, 0, 1, c, 0);
  endtask

  task automatic idle_cyc();
    cyc_drive(0, 0, 0, 0, 7'h00, 0);
  endtask

  task automatic do_reset();
    ch_valid = 0; clear_req = 0; display_on = 0;
    reset_n = 0;
    sbq.delete();
    model_reset();
    #1;
    chk("rst_pixel", pixel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_ready", ch_ready, 1);
    chk("rst_rom_digit", rom_digit, 'h20);
    chk("rst_rom_yofs", rom_yofs, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic sweep();
    for (int v = Y0 - 1; v <= Y0 + 16; v++)
      for (int h = X0 - 1; h <= X0 + 128; h++)
        cyc_drive(h, v, 1, 0, 7'h00, 0);
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      mon_e = sbq.pop_front();
      n_tests++; n_fail++;
      $display("FAIL pixel_missed: h=%0d v=%0d due=%0d now=%0d", mon_e.h, mon_e.v, mon_e.due, cyc);
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      n_tests++;
      if (pixel !== mon_e.pix) begin
        n_fail++;
        $display("FAIL pixel h=%0d v=%0d: got %0b expected %0b", mon_e.h, mon_e.v, pixel, mon_e.pix);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int guard;
    bit acc;
    reset_n = 1; hpos = 0; vpos = 0; display_on = 0;
    ch_valid = 0; ch_data = 0; clear_req = 0;
    model_reset();
    #2;
    do_reset();

    // 'H' in cell 0, rendered on glyph rows 0 and 2
    wr(7'h48);
    for (int h = X0; h < X0 + 8; h++) cyc_drive(h, Y0, 1, 0, 7'h00, 0);
    for (int h = X0; h < X0 + 8; h++) cyc_drive(h, Y0 + 2, 1, 0, 7'h00, 0);

    // window edges, display_on low, gutter rows and columns
    cyc_drive(X0 - 1, Y0, 1, 0, 7'h00, 0);
    cyc_drive(X0, Y0 + 16, 1, 0, 7'h00, 0);
    cyc_drive(X0, Y0, 0, 0, 7'h00, 0);
    cyc_drive(X0, Y0, 1, 0, 7'h00, 0);
    for (int v = Y0 + 5; v <= Y0 + 7; v++) cyc_drive(X0, v, 1, 0, 7'h00, 0);
    for (int h = X0 + 5; h <= X0 + 7; h++) cyc_drive(h, Y0, 1, 0, 7'h00, 0);

    // cursor arithmetic
    for (int i = 0; i < 17; i++) wr(7'h61);
    chk("cursor_17", cursor, 18);
    do_reset();
    for (int i = 0; i < 17; i++) wr(7'h61);
    chk("cursor_17w", cursor, 17);
    do_reset();
    for (int i = 0; i < 3; i++) wr(7'h01);
    wr(7'h0A);
    chk("cursor_lf_row1", cursor, 16);
    for (int i = 0; i < 4; i++) wr(7'h7F);
    chk("cursor_20", cursor, 20);
    wr(7'h0A);
    chk("cursor_lf_wrap", cursor, 0);
    for (int i = 0; i < 32; i++) wr(7'(i + 1 == 10 ? 11 : i + 1));
    chk("cursor_32_wrap", cursor, 0);
    sweep();

    // fill with 'H', clear with a colliding write
    do_reset();
    for (int i = 0; i < 32; i++) wr(7'h48);
    cyc_drive(0, 0, 0, 1, 7'h41, 1);
    bc = 0;
    while (busy && bc < 40) begin
      chk("clr_ready_low", ch_ready, 0);
      idle_cyc();
      bc++;
    end
    chk("clear_len", bc, 32);
    chk("clear_cursor", cursor, 0);
    sweep();

    // reset in the middle of a clear, while cell 31 still shows 'H'
    for (int i = 0; i < 32; i++) wr(7'h48);
    cyc_drive(X0 + 120, Y0 + 8, 1, 0, 7'h00, 1);
    for (int i = 0; i < 10; i++) cyc_drive(X0 + 120, Y0 + 8, 1, 0, 7'h00, 0);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_pixel", pixel, 1);
    do_reset();
    chk("post_rst_ready", ch_ready, 1);
    chk("post_rst_cursor", cursor, 0);
    sweep();

    // write held across a clear lands on the first idle cycle
    cyc_drive(0, 0, 0, 1, 7'h41, 1);
    guard = 0;
    while (guard < 40) begin
      acc = !mclr;
      cyc_drive(0, 0, 0, 1, 7'h41, 0);
      guard++;
      if (acc) break;
    end
    chk("held_write_cycles", guard, 33);
    chk("held_cursor", cursor, 1);
    cyc_drive(X0, Y0, 1, 0, 7'h00, 0);
    chk("cell0_code", rom_digit, 'h41);
    for (int h = X0; h < X0 + 8; h++) cyc_drive(h, Y0 + 1, 1, 0, 7'h00, 0);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [6:0] cd;
      cd = ($urandom % 8 == 0) ? 7'h0A : 7'($urandom);
      if ($urandom % 600 == 0) do_reset();
      cyc_drive($urandom_range(X0 + 131, X0 - 4), $urandom_range(Y0 + 17, Y0 - 2),
                ($urandom % 4) != 0, $urandom % 2, cd, ($urandom % 100) == 0);
    end

    ch_valid = 0; clear_req = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/text_renderer.md
TEXT_RENDERER -- requirements
Module: text_renderer

Interface
REQ-001 Parameter X0, default 32: left pixel column of the text window.
REQ-002 Parameter Y0, default 64: top scanline of the text window.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 hpos  in  9  current pixel column from the sync generator.
REQ-006 vpos  in  9  current scanline from the sync generator.
REQ-007 display_on  in  1  visible-region flag.
REQ-008 ch_valid  in  1  character write request.
REQ-009 ch_data  in  7  ASCII code to write.
REQ-010 ch_ready  out  1  write accepted when ch_valid & ch_ready.
REQ-011 clear_req  in  1  request to blank the whole buffer.
REQ-012 busy  out  1  high while a clear is in progress.
REQ-013 cursor  out  5  next write cell index {row, col}.
REQ-014 rom_digit  out  7  char code to glyph ROM.
REQ-015 rom_yofs  out  3  glyph row to glyph ROM.
REQ-016 rom_bits  in  5  glyph row from ROM (combinational); bit 4 = leftmost pixel.
REQ-017 pixel  out  1  registered monochrome pixel.

Function
REQ-018 Buffer SHALL be 32 cells x 7 bits, 2 rows x 16 cols; cell index = row*16+col.
REQ-019 Character cell SHALL be 8x8 px; glyph occupies cell px 0-4, lines 0-4; remainder blank.
REQ-020 Window: X0 <= hpos < X0+128 and Y0 <= vpos < Y0+16; relx=hpos-X0, rely=vpos-Y0; col=relx[6:3], px=relx[2:0], row=rely[3], gy=rely[2:0].
REQ-021 Stage 1 (cycle after hpos sample) SHALL register char=buffer[{row,col}], gy, px, and vis = in_window & display_on; rom_digit=registered char, rom_yofs=registered gy.
REQ-022 Stage 2 SHALL register pixel = vis1 & (gy1<5) & (px1<5) & rom_bits[4-px1].
REQ-023 Latency: pixel reflects hpos/vpos sampled exactly 2 cycles earlier; one hpos step per clock.
REQ-024 FSM states IDLE and CLEAR; ch_ready = (state==IDLE) & ~clear_req; busy = (state==CLEAR).
REQ-025 IDLE, accepted ch_data != 0x0A: buffer[cursor]<=ch_data, cursor<=cursor+1 mod 32 (31 wraps to 0).
REQ-026 IDLE, accepted ch_data == 0x0A: buffer unchanged, cursor<={~cursor[4],4'b0000}.
REQ-027 All other codes, including control codes, SHALL be stored verbatim.
REQ-028 IDLE & clear_req: go CLEAR, clr_idx<=0; simultaneous ch_valid not accepted (ch_ready low).
REQ-029 CLEAR: each cycle buffer[clr_idx]<=0x20, clr_idx++; after writing index 31 go IDLE, cursor<=0; duration exactly 32 cycles.
REQ-030 clear_req while in CLEAR SHALL be ignored; no restart.
REQ-031 Display path SHALL keep running during CLEAR, showing partially cleared contents.

Reset
REQ-032 reset_n low SHALL immediately force: state IDLE, all buffer cells 0x20, cursor 0, clr_idx 0, pipeline regs cleared (vis 0, char 0x20, gy 0, px 0), pixel 0, rom_digit 0x20, rom_yofs 0, busy 0.
REQ-033 Reset asserted mid-CLEAR SHALL abort the clear; post-reset state identical to REQ-032.

Verification
REQ-034 Reset; write 0x48 ('H'); hpos 32..39 consecutive, vpos 64, display_on 1 -> pixel 2 cycles later = 1,0,0,0,1,0,0,0; vpos 66 -> 1,1,1,1,1,0,0,0.
REQ-035 Write 17 chars -> cursor 17; reset, 3 chars then 0x0A -> cursor 16; cursor 20 + 0x0A -> 0; 32 non-0x0A writes from 0 -> cursor 0.
REQ-036 Fill buffer with 0x48, pulse clear_req with ch_valid high -> char dropped; busy high exactly 32 cycles, ch_ready 0 throughout; then all cells render blank, cursor 0.
REQ-037 Cell 0='H': hpos=31 or vpos=80 or display_on=0 -> pixel 0; vpos 69..71 (gy 5..7) -> pixel 0; px 5..7 -> pixel 0.
REQ-038 reset_n low at clr_idx=10 -> busy 0, pixel 0 same cycle, no clock edge needed; after release all cells 0x20, cursor 0, ch_ready 1.
REQ-039 ch_valid held with 0x41 across a clear -> accepted on first IDLE cycle only; cell 0 = 0x41, cursor 1.
